// File: rtl/galvo_spi_raster.sv
// Raster-scan galvo driver. Each rising edge of pixel_done advances the X/Y
// scan indices, computes the next mirror positions and shifts them to the
// galvo DAC as 24-bit SPI frames ({CMD_X, x_pos}, optionally {CMD_Y, y_pos}).
// galvo_spi_done then releases the master controller for the next pixel.
module galvo_spi_raster #(
    parameter int         CLK_DIV = 4,
    parameter logic [7:0] CMD_X   = 8'h31,
    parameter logic [7:0] CMD_Y   = 8'h32
) (
    input  logic        clk_adc,
    input  logic        rst_adc,
    input  logic        pixel_done,
    input  logic        scan_restart,
    input  logic        disable_galvo,
    input  logic [15:0] x_start,
    input  logic [15:0] y_start,
    input  logic [15:0] x_step,
    input  logic [15:0] y_step,
    input  logic [11:0] x_count,
    input  logic [11:0] y_count,
    output logic        galvo_sclk,
    output logic        galvo_cs_n,
    output logic        galvo_mosi,
    output logic        galvo_spi_done,
    output logic        line_done,
    output logic        frame_done,
    output logic        busy,
    output logic        overrun,
    output logic [11:0] x_idx,
    output logic [11:0] y_idx
);

    // Divider counter covers both an SCLK half-period and the 2*CLK_DIV gap.
    localparam int               CNT_W      = $clog2(2 * CLK_DIV + 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(2 * CLK_DIV - 2);
    localparam logic [4:0]       FRAME_BITS = 5'd24;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state;
    logic             pixel_q;
    logic             trigger;
    logic [CNT_W-1:0] div_cnt;
    logic [4:0]       bit_cnt;
    logic [23:0]      shift_reg;
    logic [15:0]      x_pos;
    logic [15:0]      y_pos;
    logic             pos_valid;
    logic             y_pending;
    logic             y_next;
    logic             act_restart;
    logic             restart_pending;
    logic             restart_drop;
    logic             line_wrap;
    logic             frame_wrap;

    // Next-scan-point arithmetic, consumed only by the X-frame LOAD.
    logic [11:0] x_last;
    logic [11:0] y_last;
    logic        x_wrap;
    logic        y_wrap;
    logic [15:0] cur_x;
    logic [15:0] cur_y;
    logic [11:0] nx_idx;
    logic [11:0] ny_idx;
    logic [15:0] nx_pos;
    logic [15:0] ny_pos;
    logic        n_line;
    logic        n_frame;
    logic        y_pend_new;
    logic [23:0] x_frame;
    logic [23:0] y_frame;

    // Registered edge detect on the pixel_done level.
    assign trigger = pixel_done & ~pixel_q;

    // Compute the indices/positions the next X-frame LOAD will commit.
    always_comb begin
        // A count of 0 behaves as 1: every point is the last point.
        x_last = (x_count == 12'd0) ? 12'd0 : x_count - 12'd1;
        y_last = (y_count == 12'd0) ? 12'd0 : y_count - 12'd1;
        // >= rather than == so a count reduced mid-scan still wraps cleanly.
        x_wrap = (x_idx >= x_last);
        y_wrap = (y_idx >= y_last);
        cur_x  = pos_valid ? x_pos : x_start;
        cur_y  = pos_valid ? y_pos : y_start;

        if (act_restart) begin
            nx_idx     = 12'd0;
            ny_idx     = 12'd0;
            nx_pos     = x_start;
            ny_pos     = y_start;
            n_line     = 1'b0;
            n_frame    = 1'b0;
            y_pend_new = 1'b1;
        end else begin
            nx_idx     = x_wrap ? 12'd0 : x_idx + 12'd1;
            nx_pos     = x_wrap ? x_start : cur_x + x_step;
            ny_idx     = y_idx;
            ny_pos     = cur_y;
            if (x_wrap) begin
                ny_idx = y_wrap ? 12'd0 : y_idx + 12'd1;
                ny_pos = y_wrap ? y_start : cur_y + y_step;
            end
            n_line     = x_wrap;
            n_frame    = x_wrap & y_wrap;
            y_pend_new = y_pending | x_wrap;
        end

        x_frame = {CMD_X, nx_pos};
        y_frame = {CMD_Y, y_pos};
    end

    // Scan/SPI controller: single FSM with all outputs registered.
    always_ff @(posedge clk_adc or posedge rst_adc) begin
        if (rst_adc) begin
            state           <= S_IDLE;
            pixel_q         <= 1'b0;
            div_cnt         <= '0;
            bit_cnt         <= 5'd0;
            shift_reg       <= 24'd0;
            // NOTE: the async reset loads only constants; pos_valid=0 makes
            // the next LOAD read x_start/y_start as the current position.
            x_pos           <= 16'd0;
            y_pos           <= 16'd0;
            pos_valid       <= 1'b0;
            y_pending       <= 1'b1;
            y_next          <= 1'b0;
            act_restart     <= 1'b0;
            restart_pending <= 1'b0;
            restart_drop    <= 1'b0;
            line_wrap       <= 1'b0;
            frame_wrap      <= 1'b0;
            galvo_sclk      <= 1'b0;
            galvo_cs_n      <= 1'b1;
            galvo_mosi      <= 1'b0;
            galvo_spi_done  <= 1'b0;
            line_done       <= 1'b0;
            frame_done      <= 1'b0;
            busy            <= 1'b0;
            overrun         <= 1'b0;
            x_idx           <= 12'd0;
            y_idx           <= 12'd0;
        end else begin
            pixel_q        <= pixel_done;
            // NOTE: pulses default low here and are raised only in S_DONE;
            // a later nonblocking assignment in this block overrides this one.
            galvo_spi_done <= 1'b0;
            line_done      <= 1'b0;
            frame_done     <= 1'b0;

            // Anything arriving while a pixel is in flight is recorded, not acted on.
            if (scan_restart && state != S_IDLE) begin
                restart_pending <= 1'b1;
            end
            if (trigger && state != S_IDLE) begin
                overrun <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (scan_restart || restart_pending) begin
                        // Restart wins; a coincident pixel edge is dropped.
                        state           <= S_LOAD;
                        busy            <= 1'b1;
                        act_restart     <= 1'b1;
                        restart_pending <= 1'b0;
                        restart_drop    <= trigger;
                    end else if (trigger) begin
                        state        <= S_LOAD;
                        busy         <= 1'b1;
                        act_restart  <= 1'b0;
                        restart_drop <= 1'b0;
                    end
                end

                S_LOAD: begin
                    div_cnt <= '0;
                    bit_cnt <= 5'd0;
                    if (y_next) begin
                        // Second frame of this pixel: Y position.
                        y_next     <= 1'b0;
                        y_pending  <= 1'b0;
                        shift_reg  <= y_frame;
                        galvo_mosi <= y_frame[23];
                        galvo_cs_n <= 1'b0;
                        state      <= S_SHIFT;
                    end else begin
                        x_idx      <= nx_idx;
                        y_idx      <= ny_idx;
                        x_pos      <= nx_pos;
                        y_pos      <= ny_pos;
                        pos_valid  <= 1'b1;
                        line_wrap  <= n_line;
                        frame_wrap <= n_frame;
                        y_pending  <= y_pend_new;
                        y_next     <= y_pend_new & ~disable_galvo;
                        if (act_restart) begin
                            overrun <= restart_drop | trigger;
                        end
                        if (disable_galvo) begin
                            // Indexing only; the bus stays idle.
                            state <= S_DONE;
                        end else begin
                            shift_reg  <= x_frame;
                            galvo_mosi <= x_frame[23];
                            galvo_cs_n <= 1'b0;
                            state      <= S_SHIFT;
                        end
                    end
                end

                S_SHIFT: begin
                    if (div_cnt == HALF_LAST) begin
                        div_cnt <= '0;
                        if (galvo_sclk) begin
                            // Falling edge: present the next bit (mode 0).
                            galvo_sclk <= 1'b0;
                            shift_reg  <= {shift_reg[22:0], 1'b0};
                            galvo_mosi <= shift_reg[22];
                            bit_cnt    <= bit_cnt + 5'd1;
                        end else if (bit_cnt == FRAME_BITS) begin
                            galvo_cs_n <= 1'b1;
                            galvo_mosi <= 1'b0;
                            state      <= S_GAP;
                        end else begin
                            galvo_sclk <= 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                S_GAP: begin
                    // The following LOAD/DONE cycle completes the 2*CLK_DIV gap.
                    if (div_cnt == GAP_LAST) begin
                        div_cnt <= '0;
                        state   <= y_next ? S_LOAD : S_DONE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                S_DONE: begin
                    galvo_spi_done <= 1'b1;
                    line_done      <= line_wrap;
                    frame_done     <= frame_wrap;
                    busy           <= 1'b0;
                    state          <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_galvo_spi_raster.sv
// Directed bench for galvo_spi_raster: SPI frame capture, done timing,
// scan wrapping, disable, overrun, restart and asynchronous reset.
module tb_galvo_spi_raster;

    localparam int CLK_DIV = 4;

    logic        clk_adc       = 1'b0;
    logic        rst_adc       = 1'b1;
    logic        pixel_done    = 1'b0;
    logic        scan_restart  = 1'b0;
    logic        disable_galvo = 1'b0;
    logic [15:0] x_start       = 16'h1000;
    logic [15:0] y_start       = 16'h2000;
    logic [15:0] x_step        = 16'h0010;
    logic [15:0] y_step        = 16'h0100;
    logic [11:0] x_count       = 12'd4;
    logic [11:0] y_count       = 12'd2;
    logic        galvo_sclk;
    logic        galvo_cs_n;
    logic        galvo_mosi;
    logic        galvo_spi_done;
    logic        line_done;
    logic        frame_done;
    logic        busy;
    logic        overrun;
    logic [11:0] x_idx;
    logic [11:0] y_idx;

    int n_checks = 0;
    int n_pass   = 0;

    // Results of the last captured transfer.
    logic [23:0] cap [4];
    int          n_frames;
    int          done_cyc;
    int          done_cnt;
    int          sclk_rises;
    int          cs_first;
    int          cs_len;
    logic        line_seen;
    logic        frame_seen;
    logic        busy0;

    galvo_spi_raster #(
        .CLK_DIV (CLK_DIV),
        .CMD_X   (8'h31),
        .CMD_Y   (8'h32)
    ) dut (
        .clk_adc        (clk_adc),
        .rst_adc        (rst_adc),
        .pixel_done     (pixel_done),
        .scan_restart   (scan_restart),
        .disable_galvo  (disable_galvo),
        .x_start        (x_start),
        .y_start        (y_start),
        .x_step         (x_step),
        .y_step         (y_step),
        .x_count        (x_count),
        .y_count        (y_count),
        .galvo_sclk     (galvo_sclk),
        .galvo_cs_n     (galvo_cs_n),
        .galvo_mosi     (galvo_mosi),
        .galvo_spi_done (galvo_spi_done),
        .line_done      (line_done),
        .frame_done     (frame_done),
        .busy           (busy),
        .overrun        (overrun),
        .x_idx          (x_idx),
        .y_idx          (y_idx)
    );

    always #5 clk_adc = ~clk_adc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Launch one transfer (pixel edge or restart pulse) and record the bus.
    // Cycle 0 is the cycle after the edge that samples the trigger.
    task automatic run_xfer(input bit use_restart, input int glitch_cyc);
        logic        prev_sclk;
        logic        prev_cs;
        logic [23:0] shreg;
        n_frames   = 0;
        done_cyc   = -1;
        done_cnt   = 0;
        sclk_rises = 0;
        cs_first   = -1;
        cs_len     = 0;
        line_seen  = 1'b0;
        frame_seen = 1'b0;
        busy0      = 1'b0;
        prev_sclk  = 1'b0;
        prev_cs    = 1'b1;
        shreg      = 24'd0;
        @(negedge clk_adc);
        if (use_restart) scan_restart = 1'b1;
        else pixel_done = 1'b1;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk_adc);
            @(negedge clk_adc);
            if (c == 0) begin
                scan_restart = 1'b0;
                busy0        = busy;
            end
            if (c == 10 || (glitch_cyc > 0 && c == glitch_cyc + 10)) pixel_done = 1'b0;
            if (glitch_cyc > 0 && c == glitch_cyc - 1) pixel_done = 1'b1;
            if (!galvo_cs_n && prev_cs && cs_first < 0) cs_first = c;
            if (!galvo_cs_n && n_frames == 0) cs_len++;
            if (galvo_sclk && !prev_sclk) begin
                sclk_rises++;
                shreg = {shreg[22:0], galvo_mosi};
            end
            if (galvo_cs_n && !prev_cs) begin
                if (n_frames < 4) cap[n_frames] = shreg;
                n_frames++;
                shreg = 24'd0;
            end
            if (galvo_spi_done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc   = c;
                    line_seen  = line_done;
                    frame_seen = frame_done;
                end
            end
            prev_sclk = galvo_sclk;
            prev_cs   = galvo_cs_n;
            if (done_cyc >= 0 && c >= done_cyc + 2 && c >= 12 &&
                (glitch_cyc == 0 || c > glitch_cyc + 11)) break;
        end
        pixel_done   = 1'b0;
        scan_restart = 1'b0;
    endtask

    task automatic check_xfer(input string tag, input int exp_frames,
                              input logic [23:0] f0, input logic [23:0] f1,
                              input int exp_done);
        check({tag, "_frames"}, n_frames, exp_frames);
        check({tag, "_x_frame"}, cap[0], f0);
        if (exp_frames == 2) check({tag, "_y_frame"}, cap[1], f1);
        check({tag, "_done_cyc"}, done_cyc, exp_done);
        check({tag, "_done_cnt"}, done_cnt, 1);
    endtask

    initial begin
        int          dn;
        logic [23:0] exp_x;

        // Reset state
        repeat (2) @(posedge clk_adc);
        @(negedge clk_adc);
        check("rst_sclk", galvo_sclk, 1'b0);
        check("rst_cs_n", galvo_cs_n, 1'b1);
        check("rst_mosi", galvo_mosi, 1'b0);
        check("rst_done", galvo_spi_done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_x_idx", x_idx, 12'd0);
        check("rst_y_idx", y_idx, 12'd0);
        rst_adc = 1'b0;
        repeat (2) @(negedge clk_adc);

        // First pixel after reset: pending Y frame goes out with the X frame
        run_xfer(1'b0, 0);
        check("e1_busy_c0", busy0, 1'b1);
        check("e1_cs_first", cs_first, 1);
        check("e1_cs_len", cs_len, 49 * CLK_DIV);
        check("e1_sclk_rises", sclk_rises, 48);
        check_xfer("e1", 2, 24'h311010, 24'h322000, 1 + 102 * CLK_DIV);
        check("e1_x_idx", x_idx, 12'd1);
        check("e1_line", line_seen, 1'b0);

        // X-only updates
        run_xfer(1'b0, 0);
        check("e2_cs_len", cs_len, 196);
        check("e2_sclk_rises", sclk_rises, 24);
        check_xfer("e2", 1, 24'h311020, 24'h0, 205);
        check("e2_x_idx", x_idx, 12'd2);
        run_xfer(1'b0, 0);
        check_xfer("e3", 1, 24'h311030, 24'h0, 205);

        // Line wrap: X back to start, Y stepped
        run_xfer(1'b0, 0);
        check_xfer("e4", 2, 24'h311000, 24'h322100, 409);
        check("e4_line", line_seen, 1'b1);
        check("e4_frame", frame_seen, 1'b0);
        check("e4_x_idx", x_idx, 12'd0);
        check("e4_y_idx", y_idx, 12'd1);

        for (int i = 1; i < 4; i++) begin
            run_xfer(1'b0, 0);
            exp_x = {8'h31, 16'h1000 + 16'(16 * i)};
            check_xfer($sformatf("e%0d", 4 + i), 1, exp_x, 24'h0, 205);
        end

        // Frame wrap: everything back to origin
        run_xfer(1'b0, 0);
        check_xfer("e8", 2, 24'h311000, 24'h322000, 409);
        check("e8_line", line_seen, 1'b1);
        check("e8_frame", frame_seen, 1'b1);
        check("e8_x_idx", x_idx, 12'd0);
        check("e8_y_idx", y_idx, 12'd0);

        // Disabled: indexing only, done in cycle 2
        disable_galvo = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_xfer(1'b0, 0);
            check($sformatf("dis%0d_done_cyc", i), done_cyc, 2);
            check($sformatf("dis%0d_sclk", i), sclk_rises, 0);
            check($sformatf("dis%0d_cs", i), cs_first, -1);
        end
        check("dis_line", line_seen, 1'b1);
        check("dis_x_idx", x_idx, 12'd0);
        check("dis_y_idx", y_idx, 12'd1);
        disable_galvo = 1'b0;
        // Y pending from the disabled wrap is still sent
        run_xfer(1'b0, 0);
        check_xfer("en", 2, 24'h311010, 24'h322100, 409);
        check("en_x_idx", x_idx, 12'd1);

        // Pixel edge mid-transfer is ignored and flagged
        run_xfer(1'b0, 50);
        check_xfer("ovr", 1, 24'h311020, 24'h0, 205);
        check("ovr_flag", overrun, 1'b1);
        check("ovr_x_idx", x_idx, 12'd2);
        check("ovr_y_idx", y_idx, 12'd1);

        // Restart: origin frames, overrun cleared
        run_xfer(1'b1, 0);
        check_xfer("rs", 2, 24'h311000, 24'h322000, 409);
        check("rs_overrun", overrun, 1'b0);
        check("rs_x_idx", x_idx, 12'd0);
        check("rs_y_idx", y_idx, 12'd0);

        // Reset during a transfer
        dn = 0;
        @(negedge clk_adc);
        pixel_done = 1'b1;
        for (int c = 0; c <= 102; c++) begin
            @(posedge clk_adc);
            @(negedge clk_adc);
            if (c == 10) pixel_done = 1'b0;
            if (galvo_spi_done) dn++;
        end
        check("mid_sclk", galvo_sclk, 1'b1);
        check("mid_cs_n", galvo_cs_n, 1'b0);
        rst_adc = 1'b1;
        #1;
        check("arst_sclk", galvo_sclk, 1'b0);
        check("arst_cs_n", galvo_cs_n, 1'b1);
        repeat (3) @(negedge clk_adc);
        rst_adc = 1'b0;
        check("arst_x_idx", x_idx, 12'd0);
        check("arst_y_idx", y_idx, 12'd0);
        check("arst_busy", busy, 1'b0);
        for (int c = 0; c < 450; c++) begin
            @(negedge clk_adc);
            if (galvo_spi_done) dn++;
        end
        check("arst_no_done", dn, 0);

        // Position arithmetic wraps modulo 2^16
        x_start = 16'h0008;
        x_step  = 16'hFFF0;
        run_xfer(1'b0, 0);
        check_xfer("wrap", 2, 24'h31FFF8, 24'h322000, 409);
        check("wrap_x_idx", x_idx, 12'd1);

        // x_count of 0 behaves as 1: every pixel ends a line
        x_count = 12'd0;
        run_xfer(1'b0, 0);
        check_xfer("cnt0", 2, 24'h310008, 24'h322100, 409);
        check("cnt0_line", line_seen, 1'b1);
        check("cnt0_frame", frame_seen, 1'b0);
        check("cnt0_x_idx", x_idx, 12'd0);
        check("cnt0_y_idx", y_idx, 12'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
